core_mem_dresponder: RTL and testbench

- Data-memory responder: the target end of the core's dmem request/grant interface.
- Accepts one doubleword-aligned request at a time from the LSU and applies byte-strobed writes to a local SRAM array.
- Returns read data, grant and bus error with configurable latency.
- Used as the TCM/data RAM behind the execute-stage LSU and as the reference memory model in core-level benches.

---
 rtl/core_mem_dresponder_pkg.sv | 23 ++
 rtl/core_mem_sram.sv | 39 +++
 rtl/core_mem_dresponder.sv | 150 +++++++++++++++
 tb/tb_core_mem_dresponder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_mem_dresponder_pkg.sv
// Shared definitions for the data-memory responder: bus widths, FSM encoding
// and the latency counter width.
package core_mem_dresponder_pkg;

    localparam int XL             = 64;
    localparam int MEM_ADDR_R     = XL - 1;
    localparam int MEM_STRB_R     = (XL / 8) - 1;
    localparam int MEM_DATA_R     = XL - 1;
    localparam int DMEM_LATENCY_W = 4;

    typedef enum logic [1:0] {
        DR_IDLE = 2'd0,
        DR_WAIT = 2'd1,
        DR_RESP = 2'd2,
        DR_TURN = 2'd3
    } dr_state_e;

    // Byte span covered by an array of 64-bit words.
    function automatic logic [MEM_ADDR_R:0] dmem_word_bytes(input int words);
        return (MEM_ADDR_R + 1)'(words) << 3;
    endfunction

endpackage

// File: rtl/core_mem_sram.sv
// Single-port-style data SRAM: registered read port and byte-strobed
// synchronous write port. No reset, so a hard macro can replace it directly.
module core_mem_sram
    import core_mem_dresponder_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int IDX_W     = 10
) (
    input  logic                g_clk,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [MEM_DATA_R:0] rd_data,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [MEM_STRB_R:0] wr_strb,
    input  logic [MEM_DATA_R:0] wr_data
);

    logic [MEM_DATA_R:0] mem [MEM_WORDS];

    // Registered read: output holds until the next enabled read.
    always_ff @(posedge g_clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
    end

    // Byte-lane write: only lanes with their strobe set are updated.
    always_ff @(posedge g_clk) begin
        if (wr_en) begin
            for (int i = 0; i <= MEM_STRB_R; i++) begin
                if (wr_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/core_mem_dresponder.sv
// Target end of the core dmem request/grant interface. Accepts one request at
// a time, waits LATENCY cycles (plus injected stalls), pulses dmem_gnt for one
// cycle, then spends one turnaround cycle before accepting the next request.
module core_mem_dresponder
    import core_mem_dresponder_pkg::*;
#(
    parameter int                MEM_WORDS = 1024,
    parameter logic [MEM_ADDR_R:0] BASE_ADDR = 64'h0000_0000_0001_0000,
    parameter int                LATENCY   = 1
) (
    input  logic                g_clk,
    input  logic                g_reset,
    input  logic                dmem_req,
    input  logic [MEM_ADDR_R:0] dmem_addr,
    input  logic                dmem_wen,
    input  logic [MEM_STRB_R:0] dmem_strb,
    input  logic [MEM_DATA_R:0] dmem_wdata,
    input  logic                stall_inject,
    output logic                dmem_gnt,
    output logic                dmem_err,
    output logic [MEM_DATA_R:0] dmem_rdata,
    output logic                busy
);

    localparam int                      IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [MEM_ADDR_R:0]     MEM_BYTES = dmem_word_bytes(MEM_WORDS);
    localparam logic [DMEM_LATENCY_W-1:0] CNT_LOAD = DMEM_LATENCY_W'(LATENCY - 1);

    dr_state_e                 state_q, state_d;
    logic [DMEM_LATENCY_W-1:0] cnt_q, cnt_d;
    logic                      accept;

    logic [MEM_ADDR_R:0]       addr_q;
    logic                      wen_q;
    logic [MEM_STRB_R:0]       strb_q;
    logic [MEM_DATA_R:0]       wdata_q;

    logic                      err_q;
    logic                      zero_q;

    logic [MEM_ADDR_R:0]       dec_addr;
    logic                      dec_wen;
    logic [MEM_ADDR_R:0]       dec_off;
    logic                      dec_oor;
    logic [IDX_W-1:0]          dec_idx;

    logic                      enter_resp;
    logic                      rd_en;
    logic                      wr_en;
    logic [MEM_DATA_R:0]       sram_rdata;

    // Address decode: in IDLE the request is still on the bus (LATENCY=1 enters
    // RESP straight from IDLE), afterwards the captured copy is used.
    always_comb begin
        dec_addr = (state_q == DR_IDLE) ? dmem_addr : addr_q;
        dec_wen  = (state_q == DR_IDLE) ? dmem_wen  : wen_q;
        dec_off  = dec_addr - BASE_ADDR;
        dec_oor  = (dec_addr < BASE_ADDR) || (dec_off >= MEM_BYTES);
        dec_idx  = dec_off[IDX_W+2:3];
    end

    // Next-state logic; cnt counts the WAIT cycles still owed before RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            DR_IDLE: begin
                if (dmem_req) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_LOAD;
                    state_d = (LATENCY == 1) ? DR_RESP : DR_WAIT;
                end
            end
            DR_WAIT: begin
                if (!stall_inject) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == DMEM_LATENCY_W'(1)) begin
                        state_d = DR_RESP;
                    end
                end
            end
            DR_RESP: state_d = DR_TURN;
            DR_TURN: state_d = DR_IDLE;
            default: state_d = DR_IDLE;
        endcase
    end

    assign enter_resp = (state_d == DR_RESP) && (state_q != DR_RESP) && !g_reset;
    assign rd_en      = enter_resp && !dec_wen && !dec_oor;
    assign wr_en      = (state_q == DR_RESP) && wen_q && !dec_oor && !g_reset;

    // Control state: FSM, counter and response flags.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= DR_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (enter_resp) begin
                err_q <= dec_oor;
                if (dec_oor) begin
                    zero_q <= 1'b1;
                end else if (!dec_wen) begin
                    zero_q <= 1'b0;
                end
            end
        end
    end

    // Request registers: captured once at acceptance, immune to bus changes.
    always_ff @(posedge g_clk) begin
        if (accept) begin
            addr_q  <= dmem_addr;
            wen_q   <= dmem_wen;
            strb_q  <= dmem_strb;
            wdata_q <= dmem_wdata;
        end
    end

    core_mem_sram #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_sram (
        .g_clk   (g_clk),
        .rd_en   (rd_en),
        .rd_idx  (dec_idx),
        .rd_data (sram_rdata),
        .wr_en   (wr_en),
        .wr_idx  (dec_idx),
        .wr_strb (strb_q),
        .wr_data (wdata_q)
    );

    assign dmem_gnt   = (state_q == DR_RESP);
    assign dmem_err   = dmem_gnt && err_q;
    assign dmem_rdata = zero_q ? '0 : sram_rdata;
    assign busy       = (state_q != DR_IDLE);

    // Initiator must keep its request asserted and stable while outstanding.
    a_req_held: assert property (@(posedge g_clk) disable iff (g_reset)
        (state_q == DR_WAIT) |-> dmem_req);
    a_req_stable: assert property (@(posedge g_clk) disable iff (g_reset)
        (state_q == DR_WAIT) |-> (dmem_addr == addr_q && dmem_wen == wen_q &&
                                  dmem_strb == strb_q && dmem_wdata == wdata_q));

endmodule

// File: tb/tb_core_mem_dresponder.sv
// Bench for core_mem_dresponder: two instances (LATENCY 1 and 4) driven with
// directed and random transactions, checked against an array memory model.
module tb_core_mem_dresponder;

    localparam int          MW   = 16;
    localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
    localparam logic [63:0] MB   = 64'(MW) * 64'd8;
    localparam int          LAT0 = 1;
    localparam int          LAT1 = 4;

    logic        g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    logic        rst   [2];
    logic        req   [2];
    logic [63:0] addr  [2];
    logic        wen   [2];
    logic [7:0]  strb  [2];
    logic [63:0] wdata [2];
    logic        stall [2];
    logic        gnt   [2];
    logic        err   [2];
    logic [63:0] rdata [2];
    logic        busy  [2];

    core_mem_dresponder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT0)) u_dut0 (
        .g_clk(g_clk), .g_reset(rst[0]), .dmem_req(req[0]), .dmem_addr(addr[0]),
        .dmem_wen(wen[0]), .dmem_strb(strb[0]), .dmem_wdata(wdata[0]),
        .stall_inject(stall[0]), .dmem_gnt(gnt[0]), .dmem_err(err[0]),
        .dmem_rdata(rdata[0]), .busy(busy[0]));

    core_mem_dresponder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT1)) u_dut1 (
        .g_clk(g_clk), .g_reset(rst[1]), .dmem_req(req[1]), .dmem_addr(addr[1]),
        .dmem_wen(wen[1]), .dmem_strb(strb[1]), .dmem_wdata(wdata[1]),
        .stall_inject(stall[1]), .dmem_gnt(gnt[1]), .dmem_err(err[1]),
        .dmem_rdata(rdata[1]), .busy(busy[1]));

    logic [63:0] mdl     [2][MW];
    logic [63:0] last_rd [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? LAT0 : LAT1;
    endfunction

    function automatic bit oor(input logic [63:0] a);
        return (a < BASE) || (a >= BASE + MB);
    endfunction

    // One complete transaction with checks of latency, err, gnt width and data.
    task automatic txn(input int u, input bit w, input logic [63:0] a, input logic [7:0] s,
                       input logic [63:0] wd, input int stall_n,
                       output logic [63:0] rd_o, output bit err_o);
        int          lat;
        int          exp_lat;
        bit          o;
        int          idx;
        logic [63:0] exp_rd;
        o       = oor(a);
        idx     = o ? 0 : int'((a - BASE) >> 3);
        exp_lat = lat_of(u) + ((lat_of(u) >= 3) ? stall_n : 0);
        if (o)       exp_rd = 64'd0;
        else if (!w) exp_rd = mdl[u][idx];
        else         exp_rd = last_rd[u];
        rd_o  = '0;
        err_o = 1'b0;

        @(negedge g_clk);
        req[u] = 1'b1; addr[u] = a; wen[u] = w; strb[u] = s; wdata[u] = wd;
        @(posedge g_clk); #1;
        lat = 1;
        while (!gnt[u] && lat < 40) begin
            stall[u] = (lat >= 2) && (lat < 2 + stall_n);
            @(posedge g_clk); #1;
            lat++;
        end
        stall[u] = 1'b0;
        if (!gnt[u]) begin
            chk_eq("gnt_timeout", 64'(gnt[u]), 64'd1);
            req[u] = 1'b0;
            return;
        end
        chk_eq("latency", 64'(lat), 64'(exp_lat));
        chk_eq("err", 64'(err[u]), 64'(o));
        err_o = err[u];

        @(posedge g_clk); #1;
        chk_eq("gnt_width", 64'(gnt[u]), 64'd0);
        chk_eq("rdata", rdata[u], exp_rd);
        chk_eq("busy_turn", 64'(busy[u]), 64'd1);
        rd_o = rdata[u];

        @(posedge g_clk); #1;
        chk_eq("gnt_in_turn", 64'(gnt[u]), 64'd0);
        chk_eq("rdata_hold", rdata[u], exp_rd);
        chk_eq("busy_idle", 64'(busy[u]), 64'd0);
        req[u] = 1'b0;

        if (w && !o) begin
            for (int b = 0; b < 8; b++) begin
                if (s[b]) mdl[u][idx][8*b +: 8] = wd[8*b +: 8];
            end
        end
        last_rd[u] = exp_rd;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        bit          e;
        logic [63:0] old;
        int          pulses;
        int          c;
        int          u;
        bit          w;
        logic [63:0] a;
        logic [7:0]  s;

        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; req[i] = 1'b0; addr[i] = '0; wen[i] = 1'b0;
            strb[i] = '0; wdata[i] = '0; stall[i] = 1'b0; last_rd[i] = '0;
        end
        repeat (2) @(posedge g_clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk_eq("rst_gnt", 64'(gnt[i]), 64'd0);
            chk_eq("rst_err", 64'(err[i]), 64'd0);
            chk_eq("rst_rdata", rdata[i], 64'd0);
            chk_eq("rst_busy", 64'(busy[i]), 64'd0);
            rst[i] = 1'b0;
        end

        // Preload both arrays so the model is fully defined.
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < MW; k++)
                txn(i, 1'b1, BASE + 64'(8 * k), 8'hFF, {$urandom, $urandom}, 0, rd, e);

        // Full write then readback at LATENCY=1.
        txn(0, 1'b1, BASE + 64'h08, 8'hFF, 64'hDEAD_BEEF_0123_4567, 0, rd, e);
        chk_eq("wr_err", 64'(e), 64'd0);
        txn(0, 1'b0, BASE + 64'h08, 8'h00, 64'd0, 0, rd, e);
        chk_eq("rd_deadbeef", rd, 64'hDEAD_BEEF_0123_4567);

        // Partial strobes and an all-zero strobe.
        txn(0, 1'b1, BASE + 64'h10, 8'hFF, 64'd0, 0, rd, e);
        txn(0, 1'b1, BASE + 64'h10, 8'h30, 64'h0000_AABB_0000_0000, 0, rd, e);
        txn(0, 1'b0, BASE + 64'h10, 8'h00, 64'd0, 0, rd, e);
        chk_eq("rd_strb30", rd, 64'h0000_AABB_0000_0000);
        txn(0, 1'b1, BASE + 64'h10, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 0, rd, e);
        txn(0, 1'b0, BASE + 64'h10, 8'h00, 64'd0, 0, rd, e);
        chk_eq("rd_strb00", rd, 64'h0000_AABB_0000_0000);

        // Out-of-range reads and writes on both sides of the window.
        txn(0, 1'b0, BASE - 64'd8, 8'h00, 64'd0, 0, rd, e);
        chk_eq("oor_lo_err", 64'(e), 64'd1);
        txn(0, 1'b0, BASE + MB, 8'h00, 64'd0, 0, rd, e);
        chk_eq("oor_hi_err", 64'(e), 64'd1);
        txn(0, 1'b1, BASE - 64'd8, 8'hFF, 64'h1111_2222_3333_4444, 0, rd, e);
        txn(0, 1'b1, BASE + MB, 8'hFF, 64'h5555_6666_7777_8888, 0, rd, e);
        txn(0, 1'b0, BASE, 8'h00, 64'd0, 0, rd, e);
        txn(0, 1'b0, BASE + MB - 64'd8, 8'h00, 64'd0, 0, rd, e);

        // LATENCY=4 with three stall cycles mid-WAIT: grant after 7 cycles.
        txn(1, 1'b0, BASE + 64'h18, 8'h00, 64'd0, 3, rd, e);

        // Request held continuously: next grant exactly LATENCY+2 after the first.
        @(negedge g_clk);
        req[1] = 1'b1; addr[1] = BASE + 64'h20; wen[1] = 1'b0; strb[1] = '0; wdata[1] = '0;
        c = 0;
        while (!gnt[1] && c < 40) begin @(posedge g_clk); #1; c++; end
        chk_eq("b2b_first_gnt", 64'(gnt[1]), 64'd1);
        c = 0;
        @(posedge g_clk); #1; c++;
        while (!gnt[1] && c < 40) begin @(posedge g_clk); #1; c++; end
        chk_eq("b2b_spacing", 64'(c), 64'(LAT1 + 2));
        chk_eq("b2b_rdata", rdata[1], mdl[1][4]);
        req[1] = 1'b0;
        last_rd[1] = mdl[1][4];
        repeat (2) @(posedge g_clk);
        #1;

        // Reset during WAIT of a write abandons it.
        old = mdl[1][3];
        @(negedge g_clk);
        req[1] = 1'b1; addr[1] = BASE + 64'h18; wen[1] = 1'b1; strb[1] = 8'hFF; wdata[1] = ~old;
        @(posedge g_clk); #1;
        @(posedge g_clk); #1;
        rst[1] = 1'b1;
        @(posedge g_clk); #1;
        chk_eq("midrst_gnt", 64'(gnt[1]), 64'd0);
        chk_eq("midrst_err", 64'(err[1]), 64'd0);
        chk_eq("midrst_rdata", rdata[1], 64'd0);
        chk_eq("midrst_busy", 64'(busy[1]), 64'd0);
        rst[1] = 1'b0; req[1] = 1'b0;
        pulses = 0;
        repeat (8) begin @(posedge g_clk); #1; if (gnt[1]) pulses++; end
        chk_eq("midrst_no_gnt", 64'(pulses), 64'd0);
        last_rd[1] = 64'd0;
        txn(1, 1'b0, BASE + 64'h18, 8'h00, 64'd0, 0, rd, e);
        chk_eq("midrst_word_kept", rd, old);

        // Random stream over both instances.
        for (int i = 0; i < 1000; i++) begin
            u = $urandom_range(0, 1);
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0: a = BASE - 64'd8 - 64'(8 * $urandom_range(0, 3));
                1: a = BASE + MB + 64'(8 * $urandom_range(0, 3));
                2: a = {$urandom, $urandom};
                default: a = BASE + 64'(8 * $urandom_range(0, MW - 1)) + 64'($urandom_range(0, 7));
            endcase
            s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            txn(u, w, a, s, {$urandom, $urandom}, (u == 1) ? $urandom_range(0, 2) : 0, rd, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
